accum_requant: RTL and testbench

Post-adder-tree stage of the convolution datapath. Consumes the per-tile partial sums emitted by the adder tree and accumulates `pTILE_NUM` consecutive partial sums into one output pixel. It then adds a per-channel bias, applies a rounding arithmetic right shift, and saturates to `pOUT_WIDTH`. Results leave through a 2-entry output buffer with a valid/ready handshake, so the adder-tree pipeline can be stalled by downstream backpressure.

---
 rtl/accum_requant_pkg.sv | 41 ++++
 rtl/accum_out_fifo.sv | 42 ++++
 rtl/accum_requant.sv | 95 +++++++++
 tb/tb_accum_requant.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/accum_requant_pkg.sv
// Shared types and requant helpers for the accumulate/requantize stage.
// Build option: ACCUM_REQUANT_RELU_EN clamps negative results to zero.
package accum_requant_pkg;

    typedef enum logic {
        ACC = 1'b0,
        REQ = 1'b1
    } state_e;

    localparam int OUT_W = 8;

    function automatic logic signed [63:0] out_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] out_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam logic signed [63:0] OUT_MAX = out_max(OUT_W);
    localparam logic signed [63:0] OUT_MIN = out_min(OUT_W);

    // Half-up rounding shift on a wide signed value, then clamp to [lo, hi].
    function automatic logic signed [63:0] round_shift_sat(
        input logic signed [63:0] t,
        input logic        [7:0]  sh,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        logic signed [63:0] rnd;
        logic signed [63:0] r;
        rnd = (sh == 8'd0) ? 64'sd0 : (64'sd1 <<< (sh - 8'd1));
        r   = (t + rnd) >>> sh;
        if (r > hi)
            return hi;
        else if (r < lo)
            return lo;
        return r;
    endfunction

endpackage

// File: rtl/accum_out_fifo.sv
// Two-entry result buffer; simultaneous push and pop keep count and order.
module accum_out_fifo #(
    parameter int pW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [pW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    cnt,
    output logic [pW-1:0] head
);

    logic [pW-1:0] mem [2];
    logic          wp;
    logic          rp;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (pop)
                rp <= ~rp;
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rp];

endmodule

// File: rtl/accum_requant.sv
// Accumulates pTILE_NUM partial sums, adds bias, rounds, shifts and saturates.
// Build option: ACCUM_REQUANT_RELU_EN sets the lower clamp bound to zero.
module accum_requant
    import accum_requant_pkg::*;
#(
    parameter int pDATA_WIDTH  = 32,
    parameter int pACC_WIDTH   = 40,
    parameter int pOUT_WIDTH   = 8,
    parameter int pTILE_NUM    = 4,
    parameter int pSHIFT_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [pDATA_WIDTH-1:0]  in_data,
    input  logic [pDATA_WIDTH-1:0]  bias,
    input  logic [pSHIFT_WIDTH-1:0] shift,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [pOUT_WIDTH-1:0]   out_data,
    output logic                    busy
);

    localparam int CNT_W = (pTILE_NUM > 1) ? $clog2(pTILE_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(pTILE_NUM - 1);

    localparam logic signed [63:0] HI = out_max(pOUT_WIDTH);
`ifdef ACCUM_REQUANT_RELU_EN
    localparam logic signed [63:0] LO = 64'sd0;
`else
    localparam logic signed [63:0] LO = out_min(pOUT_WIDTH);
`endif

    state_e                        state;
    logic [CNT_W-1:0]              tile_cnt;
    logic signed [pACC_WIDTH-1:0]  acc;
    logic signed [pACC_WIDTH-1:0]  in_sext;
    logic signed [63:0]            t_wide;
    logic [pOUT_WIDTH-1:0]         req_data;
    logic [1:0]                    fifo_cnt;
    logic                          accept;
    logic                          push;
    logic                          pop;

    assign in_ready = !rst && state == ACC && fifo_cnt < 2'd2;
    assign accept   = in_valid && in_ready;
    assign push     = state == REQ;
    assign pop      = out_valid && out_ready;
    assign in_sext  = pACC_WIDTH'($signed(in_data));

    // Bias add done at 64 bits so neither the sum nor the rounding term can wrap.
    assign t_wide   = 64'(acc) + 64'($signed(bias));
    assign req_data = pOUT_WIDTH'(round_shift_sat(t_wide, 8'(shift), LO, HI));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACC;
            tile_cnt <= '0;
            acc      <= '0;
        end else begin
            unique case (state)
                ACC: begin
                    if (accept) begin
                        acc <= (tile_cnt == '0) ? in_sext : acc + in_sext;
                        if (tile_cnt == LAST) begin
                            tile_cnt <= '0;
                            state    <= REQ;
                        end else begin
                            tile_cnt <= tile_cnt + 1'b1;
                        end
                    end
                end
                REQ: state <= ACC;
                default: state <= ACC;
            endcase
        end
    end

    accum_out_fifo #(
        .pW(pOUT_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (req_data),
        .pop       (pop),
        .cnt       (fifo_cnt),
        .head      (out_data)
    );

    assign out_valid = fifo_cnt != 2'd0;
    assign busy      = tile_cnt != '0 || state == REQ || fifo_cnt != 2'd0;

endmodule

// File: tb/tb_accum_requant.sv
// Directed bench for accum_requant with hand-computed expected results.
module tb_accum_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] bias;
    logic [4:0]  shift;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    accum_requant dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias      (bias),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int v);
        int k;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready)
            check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_group(input string tag, input int a, input int b,
                             input int c, input int d, input int bs,
                             input int sh, input int exp);
        bias  = bs;
        shift = 5'(sh);
        push(a);
        push(b);
        push(c);
        push(d);
        @(negedge clk);
        check({tag, "_req_ready"}, in_ready, 0);
        check({tag, "_req_valid"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, $signed(out_data), exp);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        bias      = '0;
        shift     = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        run_group("round_bias", 10, 20, 30, 40, 5, 2, 26);
        run_group("pos_sat", 1000, 1000, 1000, 1000, 0, 0, 127);
`ifdef ACCUM_REQUANT_RELU_EN
        run_group("neg_sat", -1000, -1000, -1000, -1000, 0, 0, 0);
        run_group("neg_round", -3, 0, 0, 0, 0, 1, 0);
        run_group("half_neg", -5, 0, 0, 0, 0, 1, 0);
`else
        run_group("neg_sat", -1000, -1000, -1000, -1000, 0, 0, -128);
        run_group("neg_round", -3, 0, 0, 0, 0, 1, -1);
        run_group("half_neg", -5, 0, 0, 0, 0, 1, -2);
`endif
        run_group("neg_bias", 7, 0, 0, 0, -2, 1, 3);
        run_group("edge_max", 100, 20, 7, 0, 0, 0, 127);
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Backpressure: two results fill the buffer, third group stalls.
        out_ready = 1'b0;
        bias      = '0;
        shift     = '0;
        repeat (4) push(1);
        repeat (4) push(2);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_head", $signed(out_data), 4);
        end
        check("bp_valid", out_valid, 1);
        check("bp_busy", busy, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_second", $signed(out_data), 8);
        check("bp_second_valid", out_valid, 1);
        check("bp_resume_ready", in_ready, 1);
        @(negedge clk);
        check("bp_drained", out_valid, 0);
        run_group("bp_resume", 3, 3, 3, 3, 0, 0, 12);

        // Reset partway through accumulation.
        push(5);
        push(5);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        run_group("midrst_group", 1, 1, 1, 1, 0, 0, 4);

        // Reset during the REQ cycle drops the result.
        repeat (4) push(9);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reqrst_no_out", out_valid, 0);
        end
        check("reqrst_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
